csb_slave_model: RTL and testbench
==================================

# csb_slave_model

Parametrised CSB target model for the NVDLA CSB testbenches. It sits on the `slave` side of `nvdla_csb_intf` and adds the following capabilities:
- a backing register file;
- configurable response latency;
- multiple in-order outstanding requests;
- correct posted/non-posted write semantics;
- externally driven stall.

Reads return stored data, so host-side drivers and bridges can be checked for data integrity as well as handshake correctness.

## Interface
Parameters:
- `ADDR_W`, 16, CSB address width
- `DATA_W`, 32, data width
- `DEPTH`, 64, number of backing registers; power of two
- `BASE_ADDR`, 0, first decoded address
- `LATENCY`, 2, non-stalled cycles from accept to response; minimum 1
- `MAX_OUTST`, 4, maximum queued responses; minimum 1
- `DEFAULT_RDATA`, 32'hDEADBEEF, read data for out-of-range addresses

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `stall`  in  1  freezes the block while high
- `csb.valid`  in  1  request valid
- `csb.ready`  out  1  request accepted when `valid & ready`
- `csb.addr`  in  `ADDR_W`  word address
- `csb.wdat`  in  `DATA_W`  write data
- `csb.write`  in  1  1 = write, 0 = read
- `csb.nposted`  in  1  write expects `wr_complete`
- `csb.r_valid`  out  1  read response strobe
- `csb.r_data`  out  `DATA_W`  read data
- `csb.wr_complete`  out  1  non-posted write completion strobe
- `err`  out  1  present only with `CSB_SLAVE_MODEL_ERR_EN`

## Operation
- **Ready and accept**
  - `ready = !stall && (count < MAX_OUTST)`.
  - `count` is the registered queue occupancy. A pop in the same cycle does not free a slot until the next cycle.
  - Accept happens on a rising edge where `valid & ready` is high.
- **Address decode**
  - In range when `BASE_ADDR <= addr < BASE_ADDR + DEPTH`.
  - Register index is `addr - BASE_ADDR`, truncated to `$clog2(DEPTH)` bits.
- **Write accept**
  - An in-range write updates the register on the accept edge.
  - An out-of-range write is dropped.
  - If `nposted=1`, a completion entry is enqueued.
  - If `nposted=0`, nothing is enqueued and no queue slot is used.
- **Read accept**
  - Read data is captured at the accept edge: register value if in range, else `DEFAULT_RDATA`.
  - A read entry holding that data is enqueued. A later write to the same address does not change the queued data.
- **Queue**
  - In-order FIFO of depth `MAX_OUTST`. Each entry holds `{is_read, data, due}`.
  - `tick` is a counter of width `$clog2(LATENCY+1)+1` that increments only when `stall=0`.
  - `due = tick + LATENCY`, computed modulo the `tick` width.
- **Response**
  - When the queue is non-empty, `stall=0` and `head.due == tick`, the head is popped.
  - For a read head: `r_valid=1` and `r_data=data` for exactly that cycle.
  - For a write head: `wr_complete=1` for exactly that cycle.
  - At most one response per cycle. `r_data = 0` whenever `r_valid = 0`.
- **Stall**
  - While `stall` is high: `ready=0`, `tick` is frozen, and no response is issued.
  - Pending entries keep their residual latency and resume when `stall` falls.
- **Reset** (asynchronous, any time)
  - Queue flushed, `count=0`, `tick=0`, every register cleared to 0.
  - Requests in flight are lost; no response is issued for them after reset.

## Timing
- Reset values: `ready=0` while `rst` is high, then `ready=1` in the first cycle after release (if `stall=0`). `r_valid`, `r_data`, `wr_complete` and `err` are all 0.
- Accept on edge *t* with no stall gives the response in cycle *t+LATENCY*. Outputs are registered and glitch-free.
- Each cycle of stall extends the response by one cycle.
- Back-to-back accepts, one per cycle, give back-to-back responses, one per cycle, in acceptance order.
- Sustained throughput is 1 request/cycle if `MAX_OUTST >= LATENCY + 1`, otherwise `MAX_OUTST` requests per `LATENCY+1` cycles.
- Same-cycle accept and pop is legal: `count` is unchanged.
- Same-cycle write and read acceptance cannot occur (one request per cycle).
- `tick` wrap-around is harmless: equality compare, `LATENCY` is less than the counter range, entries are in order.

## Configuration
- `CSB_SLAVE_MODEL_ERR_EN` defined:
  - `err` is a sticky flag, set on the accept edge of any out-of-range access. It is cleared only by `rst`.
  - Out-of-range read and write behaviour is otherwise unchanged.
- `CSB_SLAVE_MODEL_ERR_EN` undefined: the `err` port and its logic are absent.

## Test plan
- **Write/read-back:** reset, non-posted write `addr=0x05`, `wdat=0x12345678`, then read `0x05`.
  - `wr_complete` in cycle *t+2*.
  - `r_valid` with `r_data=0x12345678` in cycle *t'+2*.
- **Posted write:** write `0x07` with `nposted=0`, then read `0x07`.
  - No `wr_complete` ever.
  - Read returns the written value; `count` is never raised by the write.
- **Outstanding limit:** `LATENCY=2`, `MAX_OUTST=4`, hold `valid` with 6 reads of `0x00`–`0x05`.
  - 6 in-order `r_valid` pulses with the correct data.
  - `ready` drops when `count==4`.
- **Stall mid-flight:** accept a read, assert `stall` for 3 cycles starting the next cycle.
  - `r_valid` appears in cycle *t+5*.
  - `ready=0` throughout the stall.
- **Out of range:** read `addr=BASE_ADDR+DEPTH`.
  - `r_data=0xDEADBEEF`.
  - `err=1` with the macro defined.
  - A write to the same address leaves all registers unchanged.
- **Reset mid-operation:** accept 3 reads, assert `rst` one cycle later.
  - No responses follow.
  - All outputs are 0.
  - A read of a previously written address returns 0.

Source files
------------

// File: rtl/csb_slave_model.sv
// rtl/csb_slave_model.sv - CSB target model with backing registers, fixed response latency and in-order outstanding queue
// Optional sticky out-of-range error flag: define CSB_SLAVE_MODEL_ERR_EN
module csb_slave_model #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 0,
    parameter int LATENCY   = 2,
    parameter int MAX_OUTST = 4,
    parameter logic [DATA_W-1:0] DEFAULT_RDATA = DATA_W'(32'hDEADBEEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              csb_valid,
    output logic              csb_ready,
    input  logic [ADDR_W-1:0] csb_addr,
    input  logic [DATA_W-1:0] csb_wdat,
    input  logic              csb_write,
    input  logic              csb_nposted,
    output logic              csb_r_valid,
    output logic [DATA_W-1:0] csb_r_data,
    output logic              csb_wr_complete
`ifdef CSB_SLAVE_MODEL_ERR_EN
    ,
    output logic              err
`endif
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(LATENCY + 1) + 1;
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic [ADDR_W:0] LO = (ADDR_W + 1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] HI = (ADDR_W + 1)'(BASE_ADDR + DEPTH);

    logic [DATA_W-1:0] regs   [DEPTH];
    logic              q_rd   [MAX_OUTST];
    logic [DATA_W-1:0] q_data [MAX_OUTST];
    logic [TW-1:0]     q_due  [MAX_OUTST];

    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [TW-1:0] tick;

    logic [ADDR_W:0] addr_x;
    logic [IW-1:0]   idx;
    logic            in_range, accept, enq, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    assign addr_x    = {1'b0, csb_addr};
    assign in_range  = (addr_x >= LO) && (addr_x < HI);
    assign idx       = IW'(csb_addr - ADDR_W'(BASE_ADDR));
    assign csb_ready = !rst && !stall && (count < CW'(MAX_OUTST));
    assign accept    = csb_valid && csb_ready;
    // Posted writes never occupy a queue slot.
    assign enq       = accept && (!csb_write || csb_nposted);
    assign pop       = !stall && (count != '0) && (q_due[head] == tick);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            tick            <= '0;
            csb_r_valid     <= 1'b0;
            csb_r_data      <= '0;
            csb_wr_complete <= 1'b0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (!stall) tick <= tick + 1'b1;
            if (pop) head <= ptr_inc(head);
            if (enq) tail <= ptr_inc(tail);
            count           <= count + CW'(enq) - CW'(pop);
            csb_r_valid     <= pop && q_rd[head];
            csb_r_data      <= (pop && q_rd[head]) ? q_data[head] : '0;
            csb_wr_complete <= pop && !q_rd[head];
            if (accept && csb_write && in_range) regs[idx] <= csb_wdat;
        end
    end

    // Queue payload needs no reset: occupancy is tracked by count/head/tail.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_rd[tail]   <= !csb_write;
            q_data[tail] <= csb_write ? '0 : (in_range ? regs[idx] : DEFAULT_RDATA);
            q_due[tail]  <= tick + TW'(LATENCY);
        end
    end

`ifdef CSB_SLAVE_MODEL_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else if (accept && !in_range) err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_csb_slave_model.sv
// tb/tb_csb_slave_model.sv - self-checking bench for csb_slave_model against a queue/age reference model
module tb_csb_slave_model;

    localparam int L     = 2;
    localparam int M     = 4;
    localparam int DEPTH = 64;
    localparam int BASE  = 0;
    localparam logic [31:0] DEF = 32'hDEADBEEF;

    logic        clk = 1'b0, rst = 1'b1, stall = 1'b0;
    logic        csb_valid = 1'b0, csb_write = 1'b0, csb_nposted = 1'b0;
    logic [15:0] csb_addr = '0;
    logic [31:0] csb_wdat = '0;
    wire         csb_ready, csb_r_valid, csb_wr_complete;
    wire  [31:0] csb_r_data;
`ifdef CSB_SLAVE_MODEL_ERR_EN
    wire         err;
`endif

    csb_slave_model #(
        .ADDR_W(16), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE),
        .LATENCY(L), .MAX_OUTST(M), .DEFAULT_RDATA(DEF)
    ) u_dut (
        .clk(clk), .rst(rst), .stall(stall),
        .csb_valid(csb_valid), .csb_ready(csb_ready), .csb_addr(csb_addr),
        .csb_wdat(csb_wdat), .csb_write(csb_write), .csb_nposted(csb_nposted),
        .csb_r_valid(csb_r_valid), .csb_r_data(csb_r_data),
        .csb_wr_complete(csb_wr_complete)
`ifdef CSB_SLAVE_MODEL_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        logic [31:0] data;
        int          age;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mregs[DEPTH];
    bit          e_rv, e_wc, e_err, last_acc;
    logic [31:0] e_rd;
    int          tests = 0, fails = 0;

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < DEPTH; i++) mregs[i] = '0;
        e_rv = 0; e_wc = 0; e_rd = '0; e_err = 0;
    endtask

    function automatic bit exp_ready();
        return !rst && !stall && (mq.size() < M);
    endfunction

    // Entries age by one per unstalled cycle; the head responds once it has aged L cycles.
    task automatic step();
        bit   rdy, inr;
        ent_t e;
        @(posedge clk);
        last_acc = 0;
        if (rst) begin
            model_reset();
        end else begin
            rdy  = !stall && (mq.size() < M);
            e_rv = 0; e_wc = 0; e_rd = '0;
            if (!stall) begin
                foreach (mq[i]) mq[i].age++;
                if (mq.size() > 0 && mq[0].age == L) begin
                    e = mq.pop_front();
                    if (e.rd) begin e_rv = 1; e_rd = e.data; end
                    else e_wc = 1;
                end
            end
            if (csb_valid && rdy) begin
                last_acc = 1;
                inr = (int'(csb_addr) >= BASE) && (int'(csb_addr) < BASE + DEPTH);
                if (!inr) e_err = 1;
                if (csb_write) begin
                    if (inr) mregs[int'(csb_addr) - BASE] = csb_wdat;
                    if (csb_nposted) mq.push_back('{1'b0, 32'h0, 0});
                end else begin
                    mq.push_back('{1'b1, inr ? mregs[int'(csb_addr) - BASE] : DEF, 0});
                end
            end
        end
        #2;
    endtask

    task automatic drive(input bit v, input bit w, input bit np, input logic [15:0] a, input logic [31:0] d);
        csb_valid = v; csb_write = w; csb_nposted = np; csb_addr = a; csb_wdat = d;
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        tests++;
        if ({csb_ready, csb_r_valid, csb_wr_complete, csb_r_data} !== 35'h0) begin
            fails++;
            $display("FAIL reset_outputs: ready/rv/wc/rdata=%b/%b/%b/%h required all 0", csb_ready, csb_r_valid, csb_wr_complete, csb_r_data);
        end
`ifdef CSB_SLAVE_MODEL_ERR_EN
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL reset_err: err=%b required 0", err); end
`endif
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        tests++;
        if (csb_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: ready=%b required 1", csb_ready); end
    endtask

    task automatic test_write_read();
        int got; logic [31:0] d;
        drive(1, 1, 1, 16'h05, 32'h12345678); #1;
        tests++;
        if (csb_ready !== exp_ready()) begin fails++; $display("FAIL wr_ready: ready=%b required %b", csb_ready, exp_ready()); end
        step(); drive(0, 0, 0, 0, 0);
        got = -1;
        for (int n = 1; n <= 6; n++) begin
            step();
            tests++;
            if ({csb_r_valid, csb_wr_complete, csb_r_data} !== {e_rv, e_wc, e_rd}) begin
                fails++; $display("FAIL wr_model c%0d: rv/wc/rdata=%b/%b/%h required %b/%b/%h", n, csb_r_valid, csb_wr_complete, csb_r_data, e_rv, e_wc, e_rd);
            end
            if (csb_wr_complete && got < 0) got = n;
        end
        tests++;
        if (got != 2) begin fails++; $display("FAIL wr_complete_latency: cycle=%0d required 2", got); end
        drive(1, 0, 0, 16'h05, 0); step(); drive(0, 0, 0, 0, 0);
        got = -1; d = '0;
        for (int n = 1; n <= 6; n++) begin
            step();
            if (csb_r_valid && got < 0) begin got = n; d = csb_r_data; end
        end
        tests++;
        if (got != 2 || d !== 32'h12345678) begin
            fails++; $display("FAIL rd_back: cycle=%0d data=%h required 2/12345678", got, d);
        end
    endtask

    task automatic test_posted();
        int got, wc_seen; logic [31:0] wv, d;
        wv = $urandom;
        drive(1, 1, 0, 16'h07, wv); step();
        drive(1, 0, 0, 16'h07, 0); step(); drive(0, 0, 0, 0, 0);
        got = -1; wc_seen = 0; d = '0;
        for (int n = 1; n <= 6; n++) begin
            step();
            tests++;
            if ({csb_r_valid, csb_wr_complete, csb_r_data} !== {e_rv, e_wc, e_rd}) begin
                fails++; $display("FAIL posted_model c%0d: rv/wc/rdata=%b/%b/%h required %b/%b/%h", n, csb_r_valid, csb_wr_complete, csb_r_data, e_rv, e_wc, e_rd);
            end
            if (csb_wr_complete) wc_seen++;
            if (csb_r_valid && got < 0) begin got = n; d = csb_r_data; end
        end
        tests++;
        if (wc_seen != 0) begin fails++; $display("FAIL posted_no_complete: wr_complete pulses=%0d required 0", wc_seen); end
        tests++;
        if (got != 2 || d !== wv) begin fails++; $display("FAIL posted_readback: cycle=%0d data=%h required 2/%h", got, d, wv); end
    endtask

    task automatic test_outstanding();
        logic [31:0] vals[6];
        int k, pulses;
        for (int i = 0; i < 6; i++) begin
            vals[i] = $urandom;
            drive(1, 1, 0, 16'(i), vals[i]); step();
        end
        k = 0; pulses = 0;
        for (int c = 0; c < 40; c++) begin
            drive(k < 6, 0, 0, 16'(k), 0); #1;
            tests++;
            if (csb_ready !== exp_ready()) begin fails++; $display("FAIL outst_ready c%0d: ready=%b required %b", c, csb_ready, exp_ready()); end
            step();
            if (last_acc) k++;
            if ({csb_r_valid, csb_wr_complete, csb_r_data} !== {e_rv, e_wc, e_rd}) begin
                fails++; tests++;
                $display("FAIL outst_model c%0d: rv/wc/rdata=%b/%b/%h required %b/%b/%h", c, csb_r_valid, csb_wr_complete, csb_r_data, e_rv, e_wc, e_rd);
            end
            if (csb_r_valid && pulses < 6) begin
                tests++;
                if (csb_r_data !== vals[pulses]) begin fails++; $display("FAIL outst_data %0d: data=%h required %h", pulses, csb_r_data, vals[pulses]); end
                pulses++;
            end
            if (k == 6 && pulses == 6) break;
        end
        drive(0, 0, 0, 0, 0);
        tests++;
        if (pulses != 6) begin fails++; $display("FAIL outst_count: pulses=%0d required 6", pulses); end
    endtask

    task automatic test_stall();
        int got;
        drive(1, 0, 0, 16'h05, 0); step();
        drive(0, 0, 0, 0, 0); stall = 1'b1;
        got = -1;
        for (int s = 1; s <= 3; s++) begin
            #1;
            tests++;
            if (csb_ready !== 1'b0) begin fails++; $display("FAIL stall_ready c%0d: ready=%b required 0", s, csb_ready); end
            step();
            if (csb_r_valid && got < 0) got = s;
        end
        stall = 1'b0;
        for (int n = 4; n <= 8; n++) begin
            step();
            tests++;
            if ({csb_r_valid, csb_wr_complete, csb_r_data} !== {e_rv, e_wc, e_rd}) begin
                fails++; $display("FAIL stall_model c%0d: rv/wc/rdata=%b/%b/%h required %b/%b/%h", n, csb_r_valid, csb_wr_complete, csb_r_data, e_rv, e_wc, e_rd);
            end
            if (csb_r_valid && got < 0) got = n;
        end
        tests++;
        if (got != 5) begin fails++; $display("FAIL stall_latency: cycle=%0d required 5", got); end
    endtask

    task automatic test_out_of_range();
        int got, k, pulses; logic [31:0] d;
        drive(1, 0, 0, 16'(BASE + DEPTH), 0); step(); drive(0, 0, 0, 0, 0);
        got = -1; d = '0;
        for (int n = 1; n <= 4; n++) begin
            step();
            if (csb_r_valid && got < 0) begin got = n; d = csb_r_data; end
        end
        tests++;
        if (got != 2 || d !== 32'hDEADBEEF) begin fails++; $display("FAIL oor_read: cycle=%0d data=%h required 2/deadbeef", got, d); end
`ifdef CSB_SLAVE_MODEL_ERR_EN
        tests++;
        if (err !== 1'b1) begin fails++; $display("FAIL oor_err: err=%b required 1", err); end
`endif
        drive(1, 1, 1, 16'(BASE + DEPTH), $urandom); step(); drive(0, 0, 0, 0, 0);
        for (int n = 1; n <= 4; n++) step();
        k = 0; pulses = 0;
        for (int c = 0; c < 80; c++) begin
            drive(k < DEPTH, 0, 0, 16'(BASE + k), 0); step();
            if (last_acc) k++;
            tests++;
            if ({csb_r_valid, csb_wr_complete, csb_r_data} !== {e_rv, e_wc, e_rd}) begin
                fails++; $display("FAIL b2b_model c%0d: rv/wc/rdata=%b/%b/%h required %b/%b/%h", c, csb_r_valid, csb_wr_complete, csb_r_data, e_rv, e_wc, e_rd);
            end
            if (csb_r_valid) pulses++;
            if (pulses == DEPTH) break;
        end
        drive(0, 0, 0, 0, 0);
        tests++;
        if (pulses != DEPTH) begin fails++; $display("FAIL b2b_count: pulses=%0d required %0d", pulses, DEPTH); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 1),
                  16'(BASE + $urandom_range(0, DEPTH + 3)), $urandom);
            stall = ($urandom_range(0, 4) == 0);
            #1;
            tests++;
            if (csb_ready !== exp_ready()) begin fails++; $display("FAIL rand_ready c%0d: ready=%b required %b", c, csb_ready, exp_ready()); end
            step();
            tests++;
            if ({csb_r_valid, csb_wr_complete, csb_r_data} !== {e_rv, e_wc, e_rd}) begin
                fails++; $display("FAIL rand_model c%0d: rv/wc/rdata=%b/%b/%h required %b/%b/%h", c, csb_r_valid, csb_wr_complete, csb_r_data, e_rv, e_wc, e_rd);
            end
`ifdef CSB_SLAVE_MODEL_ERR_EN
            tests++;
            if (err !== e_err) begin fails++; $display("FAIL rand_err c%0d: err=%b required %b", c, err, e_err); end
`endif
        end
        drive(0, 0, 0, 0, 0); stall = 1'b0;
        for (int n = 0; n < 6; n++) begin
            step();
            tests++;
            if ({csb_r_valid, csb_wr_complete, csb_r_data} !== {e_rv, e_wc, e_rd}) begin
                fails++; $display("FAIL rand_drain c%0d: rv/wc/rdata=%b/%b/%h required %b/%b/%h", n, csb_r_valid, csb_wr_complete, csb_r_data, e_rv, e_wc, e_rd);
            end
        end
    endtask

    task automatic test_reset_mid();
        int got, bad; logic [31:0] d;
        drive(1, 1, 1, 16'h09, 32'hA5A55A5A); step(); drive(0, 0, 0, 0, 0);
        for (int n = 0; n < 4; n++) step();
        for (int r = 0; r < 3; r++) begin drive(1, 0, 0, 16'h09, 0); step(); end
        drive(0, 0, 0, 0, 0); step();
        rst = 1'b1; model_reset(); #1;
        tests++;
        if ({csb_ready, csb_r_valid, csb_wr_complete, csb_r_data} !== 35'h0) begin
            fails++; $display("FAIL rstmid_outputs: ready/rv/wc/rdata=%b/%b/%b/%h required all 0", csb_ready, csb_r_valid, csb_wr_complete, csb_r_data);
        end
`ifdef CSB_SLAVE_MODEL_ERR_EN
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL rstmid_err: err=%b required 0", err); end
`endif
        step(); rst = 1'b0;
        bad = 0;
        for (int n = 0; n < 8; n++) begin
            step();
            if (csb_r_valid || csb_wr_complete) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL rstmid_no_resp: responses=%0d required 0", bad); end
        drive(1, 0, 0, 16'h09, 0); step(); drive(0, 0, 0, 0, 0);
        got = -1; d = 32'hFFFFFFFF;
        for (int n = 1; n <= 4; n++) begin
            step();
            if (csb_r_valid && got < 0) begin got = n; d = csb_r_data; end
        end
        tests++;
        if (got != 2 || d !== 32'h0) begin fails++; $display("FAIL rstmid_cleared: cycle=%0d data=%h required 2/00000000", got, d); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_posted();
        test_outstanding();
        test_stall();
        test_out_of_range();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
